// File: rtl/mem_sram_pkg.sv
// mem_sram_pkg: shared types and widths for the MEM-stage SRAM controller
package mem_sram_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
endpackage

// File: rtl/mem_sram_wait_cnt.sv
// mem_sram_wait_cnt: clearable wait-state counter flagging the last cycle of a bus phase
module mem_sram_wait_cnt
    import mem_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    assign tc = cnt == CNT_W'(WAIT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || clr || tc) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage responder running each 32-bit access as two 16-bit halves on an async SRAM
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic               RD_EN,
    input  logic [31:0]        ADDR,
    input  logic [31:0]        WRITE_DATA,
    output logic [31:0]        READ_DATA,
    output logic               READY,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);
    state_t state, state_nxt;
    logic op_wr, req, in_phase, hi, tc;
    logic [SRAM_AW-2:0] word, word_in;
    logic [31:0] wdata;
    logic [SRAM_DW-1:0] lo;
    logic [CNT_W-1:0] cnt;
    assign req = WR_EN | RD_EN;
    assign word_in = (SRAM_AW-1)'((ADDR - 32'(ADDR_BASE)) >> 2);
    assign in_phase = state == LO || state == HI;
    assign hi = state == HI;
    mem_sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .clk(CLK),
        .rst_n(RST),
        .clr(!in_phase),
        .cnt(cnt),
        .tc(tc)
    );
    assign state_nxt = (state == IDLE) ? (req ? LO : IDLE) :
                       (state == DONE) ? IDLE :
                       !tc ? state :
                       (state == LO) ? HI : DONE;
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            op_wr <= 1'b0;
            word <= '0;
            wdata <= '0;
            lo <= '0;
            READ_DATA <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                op_wr <= WR_EN;
                word <= word_in;
                wdata <= WRITE_DATA;
            end
            // bus data is captured on the edge that ends each read half
            if (in_phase && tc && !op_wr) begin
                if (hi) READ_DATA <= {SRAM_DQ, lo};
                else lo <= SRAM_DQ;
            end
        end
    end
    assign READY = (state == IDLE && !req) || state == DONE;
    assign SRAM_ADDR = in_phase ? {word, hi} : '0;
    assign SRAM_WE_N = !(in_phase && op_wr && !tc);
    assign SRAM_OE_N = !(in_phase && !op_wr);
    assign SRAM_DQ = (in_phase && op_wr) ? (hi ? wdata[31:16] : wdata[15:0]) : 'z;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed bench with a cycle-count model of the SRAM controller and a 256Kx16 SRAM
module tb_mem_sram_ctrl;
    localparam int W = 5;
    localparam logic [15:0] PROBE = 16'h5A5A;
    logic CLK = 0, RST = 0, WR_EN = 0, RD_EN = 0;
    logic [31:0] ADDR = 0, WRITE_DATA = 0;
    wire [31:0] read_data;
    wire ready, sram_we_n, sram_oe_n;
    wire [17:0] sram_addr;
    wire [15:0] sram_dq;
    logic [15:0] mem [0:262143];
    int total = 0, bad = 0, cyc = 0, c0 = 0, we_low = 0;
    bit chk_en = 0;

    bit m_busy = 0, m_wr = 0;
    int m_t = 0;
    logic [16:0] m_word = 0;
    logic [31:0] m_data = 0, m_rd = 0;
    logic m_wdrive;

    always #5 CLK = ~CLK;

    mem_sram_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(1024)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .RD_EN(RD_EN), .ADDR(ADDR),
        .WRITE_DATA(WRITE_DATA), .READ_DATA(read_data), .READY(ready),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n)
    );

    // SRAM outputs on OE_N; otherwise the bench parks a probe value whenever the controller must not drive
    assign m_wdrive = m_busy && m_wr && m_t <= 2 * W;
    assign sram_dq = !sram_oe_n ? mem[sram_addr] : (m_wdrive ? 16'hzzzz : PROBE);
    always @(posedge CLK) if (!sram_we_n) mem[sram_addr] <= sram_dq;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (!sram_we_n) we_low <= we_low + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // model: time since acceptance decides the phase; a read returns the stored word
    always @(posedge CLK) begin
        if (!RST) begin
            m_busy <= 0;
            m_rd <= 0;
        end else if (!m_busy) begin
            if (WR_EN || RD_EN) begin
                m_busy <= 1;
                m_t <= 1;
                m_wr <= WR_EN;
                m_word <= 17'((ADDR - 32'd1024) >> 2);
                m_data <= WRITE_DATA;
            end
        end else begin
            if (m_t == 2 * W && !m_wr) m_rd <= {mem[{m_word, 1'b1}], mem[{m_word, 1'b0}]};
            if (m_t == 2 * W + 1) m_busy <= 0;
            else m_t <= m_t + 1;
        end
    end

    int ph, c;
    bit ip;
    logic [15:0] e_dq;
    always @(negedge CLK) if (chk_en) begin
        ph = !m_busy ? 0 : m_t <= W ? 1 : m_t <= 2 * W ? 2 : 3;
        c = ph == 1 ? m_t - 1 : m_t - W - 1;
        ip = ph == 1 || ph == 2;
        e_dq = (ip && m_wr) ? (ph == 1 ? m_data[15:0] : m_data[31:16]) :
               ip ? mem[{m_word, ph == 2}] : PROBE;
        chk("ready", 32'(ready), 32'((!m_busy && !(WR_EN || RD_EN)) || ph == 3));
        chk("we_n", 32'(sram_we_n), 32'(!(ip && m_wr && c < W - 1)));
        chk("oe_n", 32'(sram_oe_n), 32'(!(ip && !m_wr)));
        chk("sram_addr", 32'(sram_addr), ip ? 32'({m_word, ph == 2}) : 32'd0);
        chk("sram_dq", 32'(sram_dq), 32'(e_dq));
        chk("read_data", read_data, m_rd);
    end

    task automatic go_cycle(input int k);
        while (cyc < c0 + k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic at_cycle(input int k);
        do @(negedge CLK); while (cyc < c0 + k);
    endtask

    task automatic begin_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        c0 = cyc;
        WR_EN = wr;
        RD_EN = rd;
        ADDR = a;
        WRITE_DATA = d;
    endtask

    task automatic drop_req();
        WR_EN = 0;
        RD_EN = 0;
        ADDR = 32'h5555;
        WRITE_DATA = 32'h0BADF00D;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1;
        chk_en = 1;
        @(negedge CLK);
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_we_n", 32'(sram_we_n), 32'd1);
        chk("t1_oe_n", 32'(sram_oe_n), 32'd1);
        chk("t1_dq_z", 32'(sram_dq), 32'(PROBE));

        @(posedge CLK);
        #1;
        we_low = 0;
        begin_req(1, 0, 1024, 32'hDEADBEEF);
        at_cycle(0);
        chk("t2_ready_c0", 32'(ready), 32'd0);
        go_cycle(1);
        drop_req();
        at_cycle(10);
        chk("t2_ready_c10", 32'(ready), 32'd0);
        at_cycle(11);
        chk("t2_ready_c11", 32'(ready), 32'd1);
        go_cycle(13);
        chk("t2_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("t2_mem1", 32'(mem[1]), 32'h0000DEAD);
        chk("t2_we_low", 32'(we_low), 32'd8);

        begin_req(0, 1, 1024, 0);
        go_cycle(1);
        drop_req();
        at_cycle(11);
        chk("t3_ready_c11", 32'(ready), 32'd1);
        at_cycle(12);
        chk("t3_read_data", read_data, 32'hDEADBEEF);
        go_cycle(13);

        begin_req(1, 1, 1032, 32'h12345678);
        go_cycle(1);
        drop_req();
        go_cycle(13);
        chk("t4_mem4", 32'(mem[4]), 32'h00005678);
        chk("t4_mem5", 32'(mem[5]), 32'h00001234);
        chk("t4_read_data", read_data, 32'hDEADBEEF);

        begin_req(0, 1, 1024, 0);
        at_cycle(11);
        chk("t5_done1", 32'(ready), 32'd1);
        chk("t5_rd1", read_data, 32'hDEADBEEF);
        go_cycle(12);
        ADDR = 1032;
        at_cycle(12);
        chk("t5_gap", 32'(ready), 32'd0);
        go_cycle(13);
        drop_req();
        at_cycle(22);
        chk("t5_c22", 32'(ready), 32'd0);
        at_cycle(23);
        chk("t5_done2", 32'(ready), 32'd1);
        chk("t5_rd2", read_data, 32'h12345678);
        go_cycle(25);

        begin_req(1, 0, 1040, 32'hCAFEF00D);
        go_cycle(4);
        RST = 0;
        at_cycle(5);
        chk("t6_we_n", 32'(sram_we_n), 32'd1);
        chk("t6_dq_z", 32'(sram_dq), 32'(PROBE));
        chk("t6_read_data", read_data, 32'd0);
        go_cycle(6);
        drop_req();
        RST = 1;
        at_cycle(6);
        chk("t6_ready", 32'(ready), 32'd1);
        go_cycle(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Responder side of the MEM-stage memory interface. It accepts one 32-bit word read or write per request from the MEM stage and runs it as two 16-bit halves on an external asynchronous SRAM. It holds `READY` low while the access is in progress; the top level derives the pipeline `freeze_N` from `READY`. Read data is returned to the MEM stage, which forwards it into the MEM/WB pipeline register.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: clock cycles each 16-bit half occupies the SRAM bus; legal range 2..15.
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `CLK`  in  1  sole clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `WR_EN`  in  1  write request from the MEM stage.
- `RD_EN`  in  1  read request from the MEM stage.
- `ADDR`  in  32  byte address (ALU result).
- `WRITE_DATA`  in  32  store data.
- `READ_DATA`  out  32  last completed read word.
- `READY`  out  1  1 = no access pending or access completing this cycle.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_WE_N`  out  1  SRAM write strobe, active-low.
- `SRAM_OE_N`  out  1  SRAM output enable, active-low.

## Operation

**Address mapping**
- `word = (ADDR - ADDR_BASE) >> 2`, truncated to 17 bits; out-of-range addresses wrap modulo 2^17.
- `SRAM_ADDR = {word, half}`, where half is 0 for LO and 1 for HI.

**State machine: IDLE → LO → HI → DONE → IDLE.**
- IDLE:
  - A request is `WR_EN | RD_EN`. It is latched as op (write if `WR_EN`, else read) together with the word address and `WRITE_DATA`.
  - On a request, next state is LO and the counter is cleared.
  - `WR_EN` and `RD_EN` both high is treated as a write.
- LO and HI:
  - The counter runs 0..`WAIT_CYCLES`-1; at `WAIT_CYCLES`-1 the FSM advances and the counter clears.
- DONE: one cycle, then IDLE. Any request present is accepted in the following IDLE cycle, not in DONE.

**`READY`**
- Combinational: `READY = (state==IDLE & ~(WR_EN|RD_EN)) | (state==DONE)`.
- A new request therefore drops `READY` in the same cycle it appears.

**Write phase (LO carries `WRITE_DATA[15:0]`, HI carries `WRITE_DATA[31:16]`)**
- `SRAM_DQ` is driven with the half for the whole phase.
- `SRAM_WE_N` = 0 while counter < `WAIT_CYCLES`-1, and 1 on the last cycle of the phase (data/address hold).
- `SRAM_OE_N` = 1.

**Read phase**
- `SRAM_DQ` is high-Z, `SRAM_WE_N` = 1, `SRAM_OE_N` = 0.
- `SRAM_DQ` is sampled at the edge ending the last counter cycle: into lo at the end of LO, into hi at the end of HI.
- `READ_DATA` is registered `{hi, lo}`. It updates at the edge entering DONE for reads only, and holds otherwise (writes leave it unchanged).

**Outside LO/HI**
- `SRAM_DQ` = Z, `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_ADDR` = 0.

## Timing
- Reset (`RST`=0 at an edge):
  - State goes to IDLE; counter, latched op/address/data and `READ_DATA` go to 0.
  - `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0.
  - `READY` then follows its combinational rule.
- Request seen in IDLE at cycle 0:
  - LO spans cycles 1..W and HI spans cycles W+1..2W.
  - DONE, with `READY`=1, occurs at cycle 2W+1 (cycle 11 for W=5).
  - The MEM stage advances at the edge ending cycle 2W+1.
- Back-to-back requests: the next access enters LO at cycle 2W+3. One idle-gap IDLE cycle with `READY`=0 occurs between accesses.
- Inputs (`WR_EN`, `RD_EN`, `ADDR`, `WRITE_DATA`) are ignored after acceptance; only the latched copies are used.
- Reset mid-access: the access is aborted at that edge, the bus is released, and no `READ_DATA` update occurs. A partially written SRAM word is acceptable.

## Structure
- Package `mem_sram_pkg` contains:
  - the state enum (IDLE, LO, HI, DONE);
  - `SRAM_AW`=18 and `SRAM_DW`=16;
  - the counter width, derived from the `WAIT_CYCLES` maximum (4 bits).
- Sub-module `mem_sram_wait_cnt`: a clearable up-counter with a terminal-count output at `WAIT_CYCLES`-1 and synchronous active-low reset.
- Tri-state `SRAM_DQ` is driven only at the top of this module.

## Test plan
The bench uses a behavioural 256K×16 SRAM model with W=5.

1. Idle, no request → `READY`=1, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z.
2. Write 0xDEADBEEF to `ADDR`=1024:
   - `READY`=0 at cycle 0 and 1 at cycle 11;
   - SRAM[0]=0xBEEF and SRAM[1]=0xDEAD;
   - `SRAM_WE_N` is low for 4 of the 5 cycles of each phase.
3. Read `ADDR`=1024 after test 2 → `READY`=1 at cycle 11 and `READ_DATA`=0xDEADBEEF from cycle 12.
4. Write 0x12345678 to `ADDR`=1032 with `WR_EN` and `RD_EN` both high:
   - treated as a write, so SRAM[4]=0x5678 and SRAM[5]=0x1234;
   - `READ_DATA` is unchanged.
5. Back-to-back reads at 1024 then 1032 with requests held continuously:
   - first DONE at cycle 11, second DONE at cycle 23;
   - `READ_DATA` is 0xDEADBEEF then 0x12345678.
6. `RST`=0 at cycle 4 of a write:
   - next cycle: `SRAM_WE_N`=1, `SRAM_DQ`=Z, `READ_DATA`=0;
   - `READY`=1 once requests are deasserted.
